// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
//   Shared definitions for the sprite attribute table scanner:
//     - bit positions of the 18-bit sprite attribute word
//     - sprite_attr_t, the unpacked attribute word
//     - scan_state_t, the scanner FSM state encoding
//     - IDX_W, the width of a table index
//   unpack_attr() splits a raw RAM word into its fields.
// -----------------------------------------------------------------------------
package sprite_pkg;

    localparam int IDX_W     = 5;
    localparam int ATTR_W    = 18;

    localparam int X_MSB     = 17;
    localparam int X_LSB     = 14;
    localparam int Y_MSB     = 13;
    localparam int Y_LSB     = 10;
    localparam int LAYER_MSB = 9;
    localparam int LAYER_LSB = 5;
    localparam int ID_MSB    = 4;
    localparam int ID_LSB    = 0;

    typedef struct packed {
        logic [3:0] anchor_x;
        logic [3:0] anchor_y;
        logic [4:0] layer;
        logic [4:0] id;
    } sprite_attr_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } scan_state_t;

    function automatic sprite_attr_t unpack_attr(input logic [ATTR_W-1:0] w);
        sprite_attr_t a;
        a.anchor_x = w[X_MSB:X_LSB];
        a.anchor_y = w[Y_MSB:Y_LSB];
        a.layer    = w[LAYER_MSB:LAYER_LSB];
        a.id       = w[ID_MSB:ID_LSB];
        return a;
    endfunction

endpackage

// File: rtl/sprite_port_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_port_arbiter
//   Decides who owns the single RAM port each cycle: the CPU writer or the
//   table scanner. The CPU wins whenever it asks, except that after
//   STARVE_MAX consecutive cycles in which the scanner wanted the port and
//   lost, the scanner is forced through for one cycle.
//
//   Ports:
//     clock        rising-edge clock
//     rst          asynchronous active-high reset; also masks both grants
//     i_cpu_we     CPU write request
//     i_scan_req   scanner wants the port this cycle (FSM in READ)
//     o_cpu_grant  CPU owns the port this cycle (combinational)
//     o_scan_grant scanner owns the port this cycle (combinational)
// -----------------------------------------------------------------------------
module sprite_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic clock,
    input  logic rst,
    input  logic i_cpu_we,
    input  logic i_scan_req,
    output logic o_cpu_grant,
    output logic o_scan_grant
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve;
    logic             w_force_scan;

    // The counter can never pass STARVE_LIMIT: reaching it forces a scanner
    // grant, which clears it.
    assign w_force_scan = i_scan_req && (r_starve == STARVE_LIMIT);

    assign o_cpu_grant  = !rst && i_cpu_we && !w_force_scan;
    assign o_scan_grant = !rst && i_scan_req && !o_cpu_grant;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (o_scan_grant) begin
            r_starve <= '0;
        end else if (i_scan_req && o_cpu_grant) begin
            r_starve <= r_starve + 1'b1;
        end
    end

endmodule

// File: rtl/sprite_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_scan_ctrl
//   Walks the sprite attribute table once per frame_start, reading each
//   entry from a shared single-port synchronous RAM and presenting it
//   downstream. CPU writes share the same RAM port through
//   sprite_port_arbiter.
//
//   Build option: define SPRITE_SKIP_EMPTY_EN to drop entries whose layer
//   field is 0 instead of presenting them.
//
//   Ports:
//     clock, rst                      clock; asynchronous active-high reset
//     frame_start                     pulse that starts a scan when idle
//     cpu_we, cpu_addr, cpu_wdata     CPU write request
//     cpu_ack                         CPU write performed this cycle
//     mem_addr, mem_we, mem_wdata     RAM port
//     mem_rdata                       RAM data, one cycle after a read address
//     out_valid, out_ready            downstream handshake
//     out_anchor_x/_y, out_layer,
//     out_id, out_index               presented entry and its table index
//     busy                            scan in progress (FSM not IDLE)
//     frame_done                      one-cycle pulse at end of scan
//     frame_overrun                   frame_start arrived while busy
//     dbg_state                       current FSM state (scan_state_t)
//
//   Downstream handshake: out_valid rises with the entry fields and holds
//   them unchanged until a cycle with out_valid && out_ready; that cycle
//   transfers the entry. out_valid never drops without a transfer except
//   on reset.
// -----------------------------------------------------------------------------
module sprite_scan_ctrl
    import sprite_pkg::*;
#(
    parameter int NUM_ENTRIES = 32,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              cpu_we,
    input  logic [IDX_W-1:0]  cpu_addr,
    input  logic [ATTR_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [IDX_W-1:0]  mem_addr,
    output logic              mem_we,
    output logic [ATTR_W-1:0] mem_wdata,
    input  logic [ATTR_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_anchor_x,
    output logic [3:0]        out_anchor_y,
    output logic [4:0]        out_layer,
    output logic [4:0]        out_id,
    output logic [IDX_W-1:0]  out_index,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_overrun,
    output logic [2:0]        dbg_state
);

    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(NUM_ENTRIES - 1);

    scan_state_t       r_state;
    scan_state_t       w_next_state;
    logic [IDX_W-1:0]  r_index;
    sprite_attr_t      r_attr;
    logic [IDX_W-1:0]  r_out_index;
    logic [IDX_W-1:0]  r_mem_addr;
    logic [ATTR_W-1:0] r_mem_wdata;

    sprite_attr_t      w_rd_attr;
    logic              w_is_last;
    logic              w_rd_empty;
    logic              w_scan_req;
    logic              w_cpu_grant;
    logic              w_scan_grant;
    logic              w_capture;
    logic              w_idx_clear;
    logic              w_idx_inc;
    logic [IDX_W-1:0]  w_mem_addr;
    logic [ATTR_W-1:0] w_mem_wdata;

    assign w_rd_attr = unpack_attr(mem_rdata);
    assign w_is_last = (r_index == LAST_INDEX);

`ifdef SPRITE_SKIP_EMPTY_EN
    assign w_rd_empty = (w_rd_attr.layer == 5'd0);
`else
    assign w_rd_empty = 1'b0;
`endif

    sprite_port_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arbiter (
        .clock        (clock),
        .rst          (rst),
        .i_cpu_we     (cpu_we),
        .i_scan_req   (w_scan_req),
        .o_cpu_grant  (w_cpu_grant),
        .o_scan_grant (w_scan_grant)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (frame_start) w_next_state = ST_READ;
            end
            ST_READ: begin
                if (w_scan_grant) w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_rd_empty) begin
                    w_next_state = w_is_last ? ST_DONE : ST_READ;
                end else begin
                    w_next_state = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (out_ready) w_next_state = w_is_last ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy          = (r_state != ST_IDLE);
        frame_overrun = frame_start && busy;
        out_valid     = 1'b0;
        frame_done    = 1'b0;
        w_scan_req    = 1'b0;
        w_capture     = 1'b0;
        w_idx_clear   = 1'b0;
        w_idx_inc     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idx_clear = frame_start;
            end
            ST_READ: begin
                w_scan_req = 1'b1;
            end
            ST_WAIT: begin
                w_capture = 1'b1;
                w_idx_inc = w_rd_empty && !w_is_last;
            end
            ST_PRESENT: begin
                out_valid = 1'b1;
                w_idx_inc = out_ready && !w_is_last;
            end
            ST_DONE: begin
                frame_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dbg_state = r_state;

    // -------------------------------------------------- index and capture
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_index <= '0;
        end else if (w_idx_clear) begin
            r_index <= '0;
        end else if (w_idx_inc) begin
            r_index <= r_index + 1'b1;
        end
    end

    // Fields are captured from the read data only; a CPU write on the port in
    // the same cycle cannot disturb data already returned by the RAM.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_attr      <= '0;
            r_out_index <= '0;
        end else if (w_capture) begin
            r_attr      <= w_rd_attr;
            r_out_index <= r_index;
        end
    end

    assign out_anchor_x = r_attr.anchor_x;
    assign out_anchor_y = r_attr.anchor_y;
    assign out_layer    = r_attr.layer;
    assign out_id       = r_attr.id;
    assign out_index    = r_out_index;

    // ------------------------------------------------------------ RAM port
    // Address and write data are driven straight from the winner so the RAM
    // sees them this cycle; with no winner they hold the last driven value.
    always_comb begin
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        if (w_cpu_grant) begin
            w_mem_addr  = cpu_addr;
            w_mem_wdata = cpu_wdata;
        end else if (w_scan_grant) begin
            w_mem_addr  = r_index;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
        end
    end

    assign mem_addr  = w_mem_addr;
    assign mem_wdata = w_mem_wdata;
    assign mem_we    = w_cpu_grant;
    assign cpu_ack   = w_cpu_grant;

endmodule

// File: tb/tb_sprite_scan_ctrl.sv
module tb_sprite_scan_ctrl;

  localparam int N      = 32;
  localparam int STARVE = 4;
`ifdef SPRITE_SKIP_EMPTY_EN
  localparam int SKIP_N = 30;
`else
  localparam int SKIP_N = 32;
`endif

  // ---------------------------------------------------------- clock / reset
  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  logic        frame_start;
  logic        cpu_we;
  logic [4:0]  cpu_addr;
  logic [17:0] cpu_wdata;
  logic        cpu_ack;
  logic [4:0]  mem_addr;
  logic        mem_we;
  logic [17:0] mem_wdata;
  logic [17:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_anchor_x;
  logic [3:0]  out_anchor_y;
  logic [4:0]  out_layer;
  logic [4:0]  out_id;
  logic [4:0]  out_index;
  logic        busy;
  logic        frame_done;
  logic        frame_overrun;
  logic [2:0]  dbg_state;

  sprite_scan_ctrl dut (
    .clock         (clock),
    .rst           (rst),
    .frame_start   (frame_start),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_ack       (cpu_ack),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_anchor_x  (out_anchor_x),
    .out_anchor_y  (out_anchor_y),
    .out_layer     (out_layer),
    .out_id        (out_id),
    .out_index     (out_index),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun),
    .dbg_state     (dbg_state)
  );

  // ---------------------------------------------------------- RAM model
  logic [17:0] ram [N];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------------------------------------------------- bookkeeping
  int checks   = 0;
  int failures = 0;

  logic [17:0] model [N];
  logic [22:0] exp_q[$];
  logic [22:0] mon_exp;
  int hs_count, done_pulses, last_hs_cyc, done_cyc;
  bit exp_gap;

  int stall_index = -1;
  int stall_left  = 0;
  bit bp_check    = 0;
  bit bp_have     = 0;
  logic [22:0] bp_snap;

  bit starve_mon = 0;
  int starve_run, starve_events;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [17:0] wdata;
    logic        exp_ack;
    logic        exp_mem_we;
    logic [4:0]  exp_addr;
    logic [17:0] exp_wdata;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] out_word();
    return {out_index, out_anchor_x, out_anchor_y, out_layer, out_id};
  endfunction

  // ---------------------------------------------------------- scoreboard
  always @(negedge clock) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        hs_count++;
        last_hs_cyc = cyc;
        check("sb_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("sb_entry", 32'(out_word()), 32'(mon_exp));
        end
      end
      if (frame_done) begin
        done_pulses++;
        done_cyc = cyc;
      end
      if (starve_mon && dbg_state == 3'd1) begin
        if (cpu_ack) starve_run++;
        else begin
          check("starve_blocked_run", starve_run, STARVE);
          starve_events++;
          starve_run = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------- ready driver
  always begin
    @(posedge clock);
    #1;
    if (!rst && out_valid && int'(out_index) == stall_index && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
      if (bp_check) begin
        if (!bp_have) begin
          bp_snap = out_word();
          bp_have = 1'b1;
        end else begin
          check("bp_fields_stable", 32'(out_word()), 32'(bp_snap));
        end
        check("bp_state_present", dbg_state, 3'd3);
        check("bp_no_next_read", mem_addr, 5'd5);
      end
    end else begin
      out_ready = 1'b1;
    end
  end

  // ---------------------------------------------------------- driver tasks
  task automatic cpu_write(input logic [4:0] a, input logic [17:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    #1;
    check("cpu_wr_ack", cpu_ack, 1'b1);
    check("cpu_wr_addr", mem_addr, a);
    model[a] = d;
    @(posedge clock); #1;
    cpu_we = 1'b0;
  endtask

  task automatic start_frame();
    exp_gap = 1'b0;
    for (int k = 0; k < N; k++) begin
`ifdef SPRITE_SKIP_EMPTY_EN
      if (model[k][9:5] == 5'd0) continue;
`endif
      exp_q.push_back({5'(k), model[k]});
      if (k == N - 1) exp_gap = 1'b1;
    end
    hs_count = 0; done_pulses = 0; done_cyc = 0; last_hs_cyc = 0;
    frame_start = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_present(input int idx, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(posedge clock); #1;
      if (out_valid && int'(out_index) == idx) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!frame_done && n < 3000) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, "_done_seen"}, frame_done, 1'b1);
    @(posedge clock); #1;
  endtask

  task automatic end_frame(input string name, input int exp_n);
    check({name, "_outputs"}, hs_count, exp_n);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_done_pulses"}, done_pulses, 1);
    if (exp_gap) check({name, "_done_gap"}, done_cyc - last_hs_cyc, 1);
    check({name, "_idle_after"}, busy, 1'b0);
    exp_q.delete();
  endtask

  // ---------------------------------------------------------- stimulus
  initial begin : main
    bit ok;
    logic [17:0] new2;

    vecs[0] = '{1'b1, 5'd3,  18'h2AAAA, 1'b1, 1'b1, 5'd3,  18'h2AAAA};
    vecs[1] = '{1'b0, 5'd9,  18'h11111, 1'b0, 1'b0, 5'd3,  18'h2AAAA};
    vecs[2] = '{1'b1, 5'd31, 18'h3FFFF, 1'b1, 1'b1, 5'd31, 18'h3FFFF};
    vecs[3] = '{1'b0, 5'd0,  18'h00000, 1'b0, 1'b0, 5'd31, 18'h3FFFF};
    vecs[4] = '{1'b1, 5'd0,  18'h00001, 1'b1, 1'b1, 5'd0,  18'h00001};
    vecs[5] = '{1'b0, 5'd17, 18'h15555, 1'b0, 1'b0, 5'd0,  18'h00001};

    for (int k = 0; k < N; k++) ram[k] = '0;
    frame_start = 1'b0; cpu_we = 1'b1; cpu_addr = 5'd5; cpu_wdata = 18'h12345;
    out_ready = 1'b1;

    // reset state, with a CPU request pending
    #2 rst = 1'b1;
    #1;
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    check("rst_fields", 32'(out_word()), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst = 1'b0; cpu_we = 1'b0;
    @(posedge clock); #1;

    // idle port arbitration / hold table
    for (int i = 0; i < 6; i++) begin
      cpu_we = vecs[i].we; cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
      #1;
      check("vec_cpu_ack", cpu_ack, vecs[i].exp_ack);
      check("vec_mem_we", mem_we, vecs[i].exp_mem_we);
      check("vec_mem_addr", mem_addr, vecs[i].exp_addr);
      check("vec_mem_wdata", mem_wdata, vecs[i].exp_wdata);
      @(posedge clock); #1;
    end
    cpu_we = 1'b0;

    // preload table
    for (int k = 0; k < N; k++) begin
      logic [4:0] kk;
      kk = 5'(k);
      cpu_write(kk, {kk[3:0], ~kk[3:0], 5'd1, kk});
    end

    // uncontended scan with latency checks
    start_frame();
    check("lat_read", dbg_state, 3'd1);
    check("lat_busy", busy, 1'b1);
    @(posedge clock); #1;
    check("lat_wait", dbg_state, 3'd2);
    check("lat_no_valid_yet", out_valid, 1'b0);
    @(posedge clock); #1;
    check("lat_valid", out_valid, 1'b1);
    check("lat_first_index", out_index, 5'd0);
    wait_done("f1");
    end_frame("f1", N);

    // backpressure on entry 5
    bp_check = 1'b1; bp_have = 1'b0; stall_index = 5; stall_left = 10;
    start_frame();
    wait_done("bp");
    end_frame("bp", N);
    check("bp_stalled", bp_have, 1'b1);
    check("bp_stall_cycles_used", stall_left, 0);
    bp_check = 1'b0; stall_index = -1;

    // starvation: CPU rewrites entry 0 with its own value every cycle
    cpu_we = 1'b1; cpu_addr = 5'd0; cpu_wdata = model[0];
    starve_run = 0; starve_events = 0; starve_mon = 1'b1;
    start_frame();
    wait_done("starve");
    starve_mon = 1'b0; cpu_we = 1'b0;
    end_frame("starve", N);
    check("starve_events", starve_events, N);

    // overrun at output 10, plus a write to already-read entry 2
    new2 = {4'hA, 4'h5, 5'd7, 5'd2};
    start_frame();
    wait_present(10, ok);
    check("ovr_reach_10", ok, 1'b1);
    frame_start = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd2; cpu_wdata = new2;
    #1;
    check("ovr_pulse", frame_overrun, 1'b1);
    check("ovr_cpu_ack", cpu_ack, 1'b1);
    @(posedge clock); #1;
    frame_start = 1'b0; cpu_we = 1'b0;
    #1;
    check("ovr_pulse_clear", frame_overrun, 1'b0);
    check("ovr_still_busy", busy, 1'b1);
    wait_done("ovr");
    end_frame("ovr", N);
    model[2] = new2;

    // reset while presenting index 12
    stall_index = 12; stall_left = 100000;
    start_frame();
    wait_present(12, ok);
    check("rst_reach_12", ok, 1'b1);
    #2;
    rst = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd7; cpu_wdata = 18'h0F0F0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_state", dbg_state, 3'd0);
    check("mid_rst_fields", 32'(out_word()), 32'd0);
    check("mid_rst_cpu_ack", cpu_ack, 1'b0);
    check("mid_rst_mem_we", mem_we, 1'b0);
    check("mid_rst_mem_addr", mem_addr, 5'd0);
    check("mid_rst_mem_wdata", mem_wdata, 18'd0);
    exp_q.delete();
    stall_index = -1; stall_left = 0; cpu_we = 1'b0;
    @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    @(posedge clock); #1;
    check("post_rst_idle", dbg_state, 3'd0);
    check("post_rst_no_done", done_pulses, 0);

    // restart from index 0; entry 2 now carries the new value
    start_frame();
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("restart_valid", out_valid, 1'b1);
    check("restart_index0", out_index, 5'd0);
    wait_done("restart");
    end_frame("restart", N);

    // layer-0 entries 3 and 31
    cpu_write(5'd3,  {4'h3, 4'hC, 5'd0, 5'd3});
    cpu_write(5'd31, {4'hF, 4'h0, 5'd0, 5'd31});
    start_frame();
    wait_done("skip");
    end_frame("skip", SKIP_N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sprite_scan_ctrl.md
SPRITE_SCAN_CTRL -- requirements
Module: sprite_scan_ctrl

Interface
REQ-001 Parameter NUM_ENTRIES, default 32: sprite attribute table depth; legal range 2..32.
REQ-002 Parameter STARVE_MAX, default 4: consecutive CPU-blocked scan reads before the scanner is forced through.
REQ-003 Port clock, input, 1: rising-edge clock.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port frame_start, input, 1: single-cycle pulse requesting a table scan.
REQ-006 Ports cpu_we (input, 1), cpu_addr (input, 5), cpu_wdata (input, 18): CPU write request into the table.
REQ-007 Port cpu_ack, output, 1: CPU write is granted and performed this cycle.
REQ-008 Ports mem_addr (output, 5), mem_we (output, 1), mem_wdata (output, 18): single-port synchronous RAM port.
REQ-009 Port mem_rdata, input, 18: RAM read data, valid one cycle after the address is presented with mem_we low.
REQ-010 Ports out_valid (output, 1) and out_ready (input, 1): downstream handshake.
REQ-011 Ports out_anchor_x (4), out_anchor_y (4), out_layer (5), out_id (5), out_index (5), all outputs: unpacked entry and its table index.
REQ-012 Ports busy, frame_done, frame_overrun, all outputs, 1 bit each: scan active, scan-complete pulse, and ignored-start pulse.

Function
REQ-013 Word format: anchor_x=[17:14], anchor_y=[13:10], layer=[9:5], id=[4:0].
REQ-014 FSM states: IDLE, READ, WAIT, PRESENT, DONE.
REQ-015 IDLE: frame_start=1 clears the index to 0 and moves to READ.
REQ-016 READ: if the scanner holds the port, it drives mem_addr=index and mem_we=0, then moves to WAIT; otherwise it stays in READ.
REQ-017 WAIT: fields and index are registered from mem_rdata, then the FSM moves to PRESENT (or is skipped per REQ-029).
REQ-018 PRESENT: out_valid=1 with fields held stable; on out_valid&&out_ready the FSM goes to DONE if index==NUM_ENTRIES-1, else increments the index and goes to READ.
REQ-019 DONE: frame_done=1 for exactly one cycle, then IDLE.
REQ-020 Latency: frame_start sampled at edge E gives READ in E+1, WAIT in E+2, and out_valid in E+3 when uncontended.
REQ-021 busy=1 in every state except IDLE.
REQ-022 frame_start while busy is ignored, the scan is unaffected, and frame_overrun=1 for that one cycle.
REQ-023 Arbitration: the CPU owns the port whenever cpu_we=1, except per REQ-024; cpu_ack is combinational and equals the grant; on grant mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
REQ-024 A starve counter increments on each cycle in READ with the CPU granted; when it equals STARVE_MAX, the scanner is granted and cpu_ack=0 for that cycle; the counter clears on any scanner grant.
REQ-025 In IDLE, WAIT, PRESENT and DONE, CPU writes are always granted; the scanner's WAIT capture is unaffected by a same-cycle CPU write.
REQ-026 A CPU write to an entry already read this frame takes effect next frame; scan output is not retroactively changed.
REQ-027 With no CPU grant and no scanner read, mem_we=0 and mem_addr/mem_wdata hold their previous values.

Reset
REQ-028 On rst: state=IDLE, index=0, starve counter=0, all outputs 0 (out_valid, busy, frame_done, frame_overrun, cpu_ack, mem_we, all field outputs); asserting rst mid-scan abandons the scan with no frame_done.

Configuration
REQ-029 Macro SPRITE_SKIP_EMPTY_EN defined: an entry read with layer==0 is not presented; WAIT goes directly to READ for the next index, or to DONE if the index was last. Without the macro: every entry is presented, including layer 0.

Structure
REQ-030 Shared package sprite_pkg holds the field bit-position constants, an 18-bit sprite_attr_t struct, the FSM state enum, and the 5-bit index width constant.
REQ-031 One sub-module, sprite_port_arbiter, holds the grant logic and starve counter; the FSM and output registers stay in sprite_scan_ctrl.

Verification
REQ-032 Uncontended scan: table preloaded with entry k = {x=k[3:0], y=~k[3:0], layer=1, id=k}, frame_start pulse, out_ready=1 -> 32 outputs with out_index 0..31 in order, out_valid in E+3, and frame_done one cycle after the last handshake.
REQ-033 Backpressure: out_ready=0 for 10 cycles on entry 5 -> out_valid stays 1, fields stay stable, and index 6 is not read until the handshake.
REQ-034 Starvation: cpu_we held at 1 continuously through the scan -> exactly one cpu_ack=0 cycle after every 4 blocked READ cycles, and the scan completes.
REQ-035 Overrun: frame_start pulsed at output 10 -> frame_overrun=1 for one cycle, and the scan continues to index 31.
REQ-036 Skip: with SPRITE_SKIP_EMPTY_EN defined and entries 3 and 31 at layer=0 -> 30 outputs, index 3 and index 31 absent, and frame_done still pulses; without the macro -> 32 outputs.
REQ-037 Reset: rst asserted in PRESENT at index 12 -> all outputs are 0 immediately, state is IDLE, and the next frame_start restarts from index 0.
